// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory for the load/store stage.
// Valid/ready request and response channels, one access in flight.
// Sized loads and stores (byte/half/word/dword) with sign or zero extension on loads.
// Storage is a word array written through per-byte enables.
// Optional macro DMEM_MISALIGN_EN: when defined, accesses that cross a word boundary
// are split into two beats. When undefined, any access that is not size-aligned is
// rejected with an error.
module dmem_lsu #(
    parameter int    DATA_W   = 32,
    parameter int    DEPTH_W  = 14,
    parameter int    ADDR_W   = 32,
    parameter string MEM_INIT = ""
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int WORDS = 1 << DEPTH_W;

    // Byte-lane mask for an access of nbytes starting at lane, spanning two words.
    function automatic logic [2*NB-1:0] lane_mask(input logic [3:0] nbytes,
                                                  input logic [OFS_W-1:0] lane);
        logic [2*NB-1:0] m;
        m = ~({(2*NB){1'b1}} << nbytes);
        return m << lane;
    endfunction

    // Right-justified store data trimmed to nbytes and moved up to its lane.
    function automatic logic [2*DATA_W-1:0] place_wdata(input logic [DATA_W-1:0] wdata,
                                                        input logic [3:0] nbytes,
                                                        input logic [OFS_W-1:0] lane);
        logic [DATA_W-1:0]   keep;
        logic [2*DATA_W-1:0] d;
        keep = ~({DATA_W{1'b1}} << {nbytes, 3'b000});
        d    = {{DATA_W{1'b0}}, wdata & keep};
        return d << {lane, 3'b000};
    endfunction

    // Pull the addressed bytes down to bit 0 from a {high word, low word} pair.
    function automatic logic [DATA_W-1:0] gather(input logic [2*DATA_W-1:0] pair,
                                                 input logic [OFS_W-1:0] lane);
        logic [2*DATA_W-1:0] s;
        s = pair >> {lane, 3'b000};
        return s[DATA_W-1:0];
    endfunction

    // Sign or zero extension of a load from its top loaded bit.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0] size,
                                                      input logic uns);
        logic [DATA_W-1:0] keep;
        logic [3:0]        nbytes;
        logic              msb;
        nbytes = 4'd1 << size;
        keep   = ~({DATA_W{1'b1}} << {nbytes, 3'b000});
        case (size)
            2'd0:    msb = raw[7];
            2'd1:    msb = raw[15];
            2'd2:    msb = raw[31];
            default: msb = raw[DATA_W-1];
        endcase
        return (raw & keep) | ({DATA_W{msb & ~uns}} & ~keep);
    endfunction

    // Storage; contents survive reset.
    logic [DATA_W-1:0] mem [0:WORDS-1];

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i[DEPTH_W-1:0]] = '0;
    end

    logic                accept;
    logic                idle;
    logic [OFS_W-1:0]    req_lane;
    logic [DEPTH_W-1:0]  req_word;
    logic [3:0]          req_bytes;
    logic                req_size_err;
    logic                req_err;
    logic [2*NB-1:0]     req_be_wide;
    logic [2*DATA_W-1:0] req_wdata_wide;
    logic [DATA_W-1:0]   req_rd_word;

    logic                wr_en;
    logic [DEPTH_W-1:0]  wr_word;
    logic [NB-1:0]       wr_be;
    logic [DATA_W-1:0]   wr_data;

    // Address bits above the array size alias onto the same words.
    generate
        if (ADDR_W > DEPTH_W + OFS_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^i_req_addr[ADDR_W-1:DEPTH_W+OFS_W];
        end
    endgenerate

    assign req_lane       = i_req_addr[OFS_W-1:0];
    assign req_word       = i_req_addr[DEPTH_W+OFS_W-1:OFS_W];
    assign req_bytes      = 4'd1 << i_req_size;
    assign req_size_err   = (DATA_W == 32) && (i_req_size == 2'd3);
    assign req_be_wide    = lane_mask(req_bytes, req_lane);
    assign req_wdata_wide = place_wdata(i_req_wdata, req_bytes, req_lane);
    assign req_rd_word    = mem[req_word];

    assign o_req_ready = idle && (!o_rsp_valid || i_rsp_ready);
    assign accept      = i_req_valid && o_req_ready;

`ifdef DMEM_MISALIGN_EN
    typedef enum logic {S_IDLE, S_BEAT2} state_t;

    state_t              state;
    logic [DEPTH_W-1:0]  req_word_nxt;
    logic                req_cross;
    logic [DEPTH_W-1:0]  b2_word;
    logic [OFS_W-1:0]    b2_lane;
    logic [1:0]          b2_size;
    logic                b2_uns;
    logic                b2_we;
    logic [DATA_W-1:0]   b2_lo;
    logic [NB-1:0]       b2_be;
    logic [DATA_W-1:0]   b2_wdata;
    logic [DATA_W-1:0]   b2_rd_hi;

    assign idle         = (state == S_IDLE);
    assign req_word_nxt = req_word + DEPTH_W'(1);
    assign req_cross    = (int'(req_lane) + int'(req_bytes)) > NB;
    assign req_err      = req_size_err;
    assign b2_rd_hi     = mem[b2_word];

    // Second-beat context captured when a request is accepted.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            b2_word  <= req_word_nxt;
            b2_lane  <= req_lane;
            b2_size  <= i_req_size;
            b2_uns   <= i_req_unsigned;
            b2_we    <= i_req_we;
            b2_lo    <= req_rd_word;
            b2_be    <= req_be_wide[2*NB-1:NB];
            b2_wdata <= req_wdata_wide[2*DATA_W-1:DATA_W];
        end
    end
`else
    logic [2:0] req_align_mask;
    logic       req_misaligned;
    logic       unused_hi;

    assign idle           = 1'b1;
    assign req_align_mask = 3'(req_bytes - 4'd1);
    assign req_misaligned = (i_req_addr[2:0] & req_align_mask) != 3'd0;
    assign req_err        = req_size_err | req_misaligned;
    assign unused_hi      = ^{req_be_wide[2*NB-1:NB], req_wdata_wide[2*DATA_W-1:DATA_W]};
`endif

    // Select which beat drives the byte-enabled write port this cycle.
    always_comb begin
        wr_en   = accept && i_req_we && !req_err;
        wr_word = req_word;
        wr_be   = req_be_wide[NB-1:0];
        wr_data = req_wdata_wide[DATA_W-1:0];
`ifdef DMEM_MISALIGN_EN
        if (state == S_BEAT2) begin
            wr_en   = b2_we;
            wr_word = b2_word;
            wr_be   = b2_be;
            wr_data = b2_wdata;
        end
`endif
    end

    // Byte-masked memory write.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[wr_word][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Access sequencing and registered response; response holds until consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
`ifdef DMEM_MISALIGN_EN
            state       <= S_IDLE;
`endif
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (o_rsp_valid && i_rsp_ready) o_rsp_valid <= 1'b0;
            if (accept) begin
                if (req_err) begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b1;
                    o_rsp_rdata <= '0;
                end
`ifdef DMEM_MISALIGN_EN
                else if (req_cross) begin
                    state <= S_BEAT2;
                end
`endif
                else begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b0;
                    o_rsp_rdata <= i_req_we ? '0 :
                        extend_load(gather({{DATA_W{1'b0}}, req_rd_word}, req_lane),
                                    i_req_size, i_req_unsigned);
                end
            end
`ifdef DMEM_MISALIGN_EN
            if (state == S_BEAT2) begin
                state       <= S_IDLE;
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b0;
                o_rsp_rdata <= b2_we ? '0 :
                    extend_load(gather({b2_rd_hi, b2_lo}, b2_lane), b2_size, b2_uns);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table, hand-written backpressure and reset sequences,
// and randomized traffic checked against a byte-array reference model.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    dmem_lsu #(
        .DATA_W  (32),
        .DEPTH_W (8),
        .ADDR_W  (32),
        .MEM_INIT("")
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_addr    (req_addr),
        .i_req_size    (req_size),
        .i_req_unsigned(req_uns),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: 1 KiB of bytes, address taken modulo capacity.
    byte unsigned mm [1024];

    function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er, output int lat);
        int nb;
        int a;
        logic [31:0] v;
        nb  = 1 << size;
        a   = int'(addr % 1024);
        rd  = '0;
        lat = 1;
        er  = (size == 2'd3);
`ifdef DMEM_MISALIGN_EN
        if (!er && ((addr % 4) + nb) > 4) lat = 2;
`else
        if ((addr % nb) != 0) er = 1'b1;
`endif
        if (er) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mm[(a + i) % 1024] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(mm[(a + i) % 1024]) << (8 * i));
            if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd = v;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One complete transaction with the response accepted immediately.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_uns = uns; req_wdata = wd; rsp_ready = 1'b1;
        rd = '0; er = 1'b0; lat = 0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin n++; @(negedge clk); end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready=0 want ready=1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got valid=0 want valid=1 within 10 cycles");
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        logic [1:0]  lat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                                input logic er, input logic [1:0] lat);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns;
        v.wd = wd; v.rd = rd; v.er = er; v.lat = lat;
        return v;
    endfunction

    initial begin
        logic [31:0] rd, mrd, exp1, exp2, addr;
        logic        er, mer, we, uns;
        logic [1:0]  size;
        int          lat, mlat;
        vec_t        v;

`ifdef DMEM_MISALIGN_EN
        tbl.push_back(mk(1, 32'h0FE, 2, 0, 32'h1122_3344, 32'h0, 0, 2));
        tbl.push_back(mk(0, 32'h0FC, 2, 0, 32'h0,         32'h3344_0000, 0, 1));
        tbl.push_back(mk(0, 32'h100, 2, 0, 32'h0,         32'h0000_1122, 0, 1));
        tbl.push_back(mk(0, 32'h0FE, 2, 0, 32'h0,         32'h1122_3344, 0, 2));
`endif
        tbl.push_back(mk(1, 32'h100, 2, 0, 32'hDEAD_BEEF, 32'h0,         0, 1));
        tbl.push_back(mk(0, 32'h100, 2, 0, 32'h0,         32'hDEAD_BEEF, 0, 1));
        tbl.push_back(mk(1, 32'h203, 0, 0, 32'h0000_0080, 32'h0,         0, 1));
        tbl.push_back(mk(0, 32'h203, 0, 0, 32'h0,         32'hFFFF_FF80, 0, 1));
        tbl.push_back(mk(0, 32'h203, 0, 1, 32'h0,         32'h0000_0080, 0, 1));
        tbl.push_back(mk(0, 32'h200, 2, 0, 32'h0,         32'h8000_0000, 0, 1));
        tbl.push_back(mk(0, 32'h202, 1, 0, 32'h0,         32'hFFFF_8000, 0, 1));
        tbl.push_back(mk(1, 32'h300, 3, 0, 32'hFFFF_FFFF, 32'h0,         1, 1));
        tbl.push_back(mk(0, 32'h300, 3, 0, 32'h0,         32'h0,         1, 1));
        tbl.push_back(mk(0, 32'h300, 2, 0, 32'h0,         32'h0,         0, 1));
        tbl.push_back(mk(1, 32'h002, 1, 0, 32'hABCD_5678, 32'h0,         0, 1));
        tbl.push_back(mk(0, 32'h000, 2, 0, 32'h0,         32'h5678_0000, 0, 1));
        tbl.push_back(mk(0, 32'h002, 1, 1, 32'h0,         32'h0000_5678, 0, 1));
        tbl.push_back(mk(0, 32'h402, 1, 0, 32'h0,         32'h0000_5678, 0, 1));
`ifndef DMEM_MISALIGN_EN
        tbl.push_back(mk(1, 32'h101, 1, 0, 32'h0000_1234, 32'h0,         1, 1));
        tbl.push_back(mk(0, 32'h100, 2, 0, 32'h0,         32'hDEAD_BEEF, 0, 1));
        tbl.push_back(mk(0, 32'h102, 2, 0, 32'h0,         32'h0,         1, 1));
`endif

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_uns = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            model(v.we, v.addr, v.size, v.uns, v.wd, mrd, mer, mlat);
            xfer(v.we, v.addr, v.size, v.uns, v.wd, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, v.rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(v.er));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.lat));
        end

        // Backpressure: first response held 5 cycles, second request waits
        model(0, 32'h100, 2, 0, 32'h0, exp1, mer, mlat);
        model(0, 32'h200, 2, 0, 32'h0, exp2, mer, mlat);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_uns = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_addr = 32'h200;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata, exp1);
            chk($sformatf("bp_hold%0d_err", k), 32'(rsp_err), 32'd0);
            chk($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        #1;
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_valid", 32'(rsp_valid), 32'd1);
        chk("bp_second_rdata", rsp_rdata, exp2);
        @(posedge clk); #1;
        chk("bp_second_consumed", 32'(rsp_valid), 32'd0);

        // Asynchronous reset while an access is in flight
`ifdef DMEM_MISALIGN_EN
        addr = 32'h0FE;
`else
        addr = 32'h100;
`endif
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_size = 2'd2; req_uns = 1'b0;
        @(negedge clk);
        chk("rst_seq_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 32'd0);
        chk("rst_async_rdata", rsp_rdata, 32'd0);
        chk("rst_async_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_after_req_ready", 32'(req_ready), 32'd1);
        chk("rst_after_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        model(0, addr, 2, 0, 32'h0, mrd, mer, mlat);
        xfer(0, addr, 2, 0, 32'h0, rd, er, lat);
        chk("rst_mem_preserved_rdata", rd, mrd);
        chk("rst_mem_preserved_latency", 32'(lat), 32'(mlat));

        // Randomized traffic near the top/bottom wrap point with aliasing high bits
        for (int i = 0; i < 300; i++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            addr[9:0] = 10'((32'h3E0 + $urandom_range(0, 63)) & 32'h3FF);
            if ($urandom_range(0, 1) == 1 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            req_wdata = $urandom;
            model(we, addr, size, uns, req_wdata, mrd, mer, mlat);
            xfer(we, addr, size, uns, req_wdata, rd, er, lat);
            chk($sformatf("rand%0d_rdata", i), rd, mrd);
            chk($sformatf("rand%0d_err", i), 32'(er), 32'(mer));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(mlat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
